// File: rtl/mem_bridge.sv
// mem_bridge: turns one MEM-stage load/store into a single request on a simple
// memory bus and stalls the pipeline until the access completes.
//
// FSM: IDLE -> REQ (bus request held until bus_ack) -> DONE (1 cycle) -> IDLE.
// Every FSM output is registered except stall, which is combinational so the
// pipeline freezes in the same cycle the request is accepted.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a REQ that sees no bus_ack for TIMEOUT_CYCLES cycles is
//   abandoned: the FSM enters DONE with a one-cycle bus_err pulse, and a load
//   returns 32'h0 with rdata_valid. When undefined, REQ waits forever and
//   bus_err is tied low.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   req_valid/we/addr    MEM-stage access (we: 1 = store, 0 = load)
//   req_wdata/byte_en    lane-aligned store data and byte lanes
//   stall                pipeline freeze
//   rdata, rdata_valid   raw load word and load-completion pulse
//   bus_req/we/addr      bus request (addr is word aligned)
//   bus_wdata/be         bus store data and byte enables
//   bus_ack, bus_rdata   bus response
//   bus_err              timeout pulse
module mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byte_en,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Registered outputs and the latched access type.
    logic        bus_req_q,     bus_req_d;
    logic        bus_we_q,      bus_we_d;
    logic [31:0] bus_addr_q,    bus_addr_d;
    logic [31:0] bus_wdata_q,   bus_wdata_d;
    logic [3:0]  bus_be_q,      bus_be_d;
    logic [31:0] rdata_q,       rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        bus_err_q,     bus_err_d;
    logic        is_load_q,     is_load_d;

    // A store with no byte lanes is a no-op and never leaves IDLE.
    logic accept;
    assign accept = req_valid && !(req_we && (req_byte_en == 4'b0000));

    // Byte offset is dropped: the bus is word addressed.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[1:0];

    logic timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Counts REQ cycles; cleared as the FSM enters REQ. The compare fires in
    // the TIMEOUT_CYCLES-th REQ cycle, so the access is abandoned after
    // exactly TIMEOUT_CYCLES cycles of waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE && accept) begin
            cnt_q <= '0;
        end else if (state_q == S_REQ) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // An ack in the same cycle wins, so timeout is qualified with !bus_ack.
    assign timeout = (state_q == S_REQ) && !bus_ack &&
                     (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. req_valid seen in DONE is the instruction just completed,
    // so DONE always returns to IDLE without looking at it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_REQ;
            S_REQ:   if (bus_ack || timeout) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-state. Bus fields are loaded on acceptance and held by
    // default, so they stay stable for the whole REQ phase.
    always_comb begin
        bus_req_d     = 1'b0;
        bus_be_d      = 4'b0000;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        is_load_d     = is_load_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        bus_err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = req_we;
                    bus_addr_d  = {req_addr[31:2], 2'b00};
                    bus_wdata_d = req_wdata;
                    bus_be_d    = req_we ? req_byte_en : 4'b1111;
                    is_load_d   = !req_we;
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    if (is_load_q) begin
                        rdata_d       = bus_rdata;
                        rdata_valid_d = 1'b1;
                    end
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    if (is_load_q) begin
                        rdata_d       = 32'h0;
                        rdata_valid_d = 1'b1;
                    end
                end else begin
                    bus_req_d = 1'b1;
                    bus_be_d  = bus_be_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'h0;
            bus_wdata_q   <= 32'h0;
            bus_be_q      <= 4'b0000;
            is_load_q     <= 1'b0;
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
            is_load_q     <= is_load_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign stall       = ((state_q == S_IDLE) && accept) || (state_q == S_REQ);
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_be      = bus_be_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_byte_en;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] last_rd;

    mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_byte_en(req_byte_en),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one access, holding req_valid until the DONE cycle, and reports
    // what it observed. ack_delay < 0 means never ack.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input int ack_delay, input logic [31:0] rdv,
                             output int stall_cyc, output int req_cyc,
                             output int unstable, output int rv_cyc,
                             output int err_cyc, output bus_t snap,
                             output logic [31:0] rd_seen);
        bit started = 0;
        bit done_seen = 0;
        stall_cyc = 0; req_cyc = 0; unstable = 0; rv_cyc = 0; err_cyc = 0;
        snap = '0; rd_seen = 32'hx;
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wdata; req_byte_en = be; bus_ack = 1'b0; bus_rdata = rdv;
        #1;
        for (int c = 0; c < ack_delay + 10; c++) begin
            if (stall) begin stall_cyc++; started = 1; end
            if (bus_err) err_cyc++;
            if (rdata_valid) begin rv_cyc++; rd_seen = rdata; end
            if (bus_req) begin
                if (req_cyc == 0) snap = {bus_we, bus_addr, bus_be, bus_wdata};
                else if ({bus_we, bus_addr, bus_be, bus_wdata} !== snap) unstable++;
                bus_ack = (req_cyc == ack_delay);
                req_cyc++;
            end else begin
                bus_ack = 1'b0;
            end
            if (started && !stall && !done_seen) begin
                done_seen = 1;
                req_valid = 1'b0;
            end
            tick();
        end
        req_valid = 1'b0;
        bus_ack = 1'b0;
        if (started && !done_seen) begin
            n_tests++; n_fail++;
            $display("FAIL access_timeout: access still stalled after budget");
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_byte_en = '0; bus_ack = 1'b0; bus_rdata = '0;
        tick(); tick();
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_tests++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        n_tests++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we: got %b want 0", bus_we); end
        n_tests++; if (bus_be !== 4'b0) begin n_fail++; $display("FAIL reset_bus_be: got %h want 0", bus_be); end
        n_tests++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_tests++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_valid: got %b want 0", rdata_valid); end
        n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        reset = 1'b0;
        last_rd = 32'h0;
        tick();
    endtask

    task automatic test_load(input logic [31:0] addr, input logic [31:0] data,
                             input int ack_delay);
        int sc, rc, un, rv, ec;
        bus_t snap, eb;
        logic [31:0] rd, er;
        exp_rd_q.push_back(data);
        exp_bus_q.push_back('{we: 1'b0, addr: {addr[31:2], 2'b00}, be: 4'b1111, wdata: 32'h0});
        do_access(1'b0, addr, 32'h0, 4'b0000, ack_delay, data, sc, rc, un, rv, ec, snap, rd);
        n_tests++; if (sc !== ack_delay + 2) begin n_fail++; $display("FAIL load_stall_cycles: got %0d want %0d", sc, ack_delay + 2); end
        n_tests++; if (rc !== ack_delay + 1) begin n_fail++; $display("FAIL load_req_cycles: got %0d want %0d", rc, ack_delay + 1); end
        n_tests++; if (un !== 0) begin n_fail++; $display("FAIL load_bus_stable: %0d unstable cycles, want 0", un); end
        n_tests++; if (rv !== 1) begin n_fail++; $display("FAIL load_rdata_valid: got %0d pulses want 1", rv); end
        eb = exp_bus_q.pop_front();
        n_tests++; if (snap !== eb) begin n_fail++; $display("FAIL load_bus: got %h want %h", snap, eb); end
        er = exp_rd_q.pop_front();
        n_tests++; if (rd !== er) begin n_fail++; $display("FAIL load_rdata: got %h want %h", rd, er); end
        n_tests++; if (rdata !== er) begin n_fail++; $display("FAIL load_rdata_hold: got %h want %h", rdata, er); end
        last_rd = er;
    endtask

    task automatic test_store;
        int sc, rc, un, rv, ec;
        bus_t snap, eb;
        logic [31:0] rd;
        exp_bus_q.push_back('{we: 1'b1, addr: 32'h0000_3000, be: 4'b1100, wdata: 32'hABCD_0000});
        do_access(1'b1, 32'h0000_3002, 32'hABCD_0000, 4'b1100, 3, 32'h5555_AAAA,
                  sc, rc, un, rv, ec, snap, rd);
        n_tests++; if (sc !== 5) begin n_fail++; $display("FAIL store_stall_cycles: got %0d want 5", sc); end
        n_tests++; if (rc !== 4) begin n_fail++; $display("FAIL store_req_cycles: got %0d want 4", rc); end
        n_tests++; if (un !== 0) begin n_fail++; $display("FAIL store_bus_stable: %0d unstable cycles, want 0", un); end
        n_tests++; if (rv !== 0) begin n_fail++; $display("FAIL store_rdata_valid: got %0d pulses want 0", rv); end
        eb = exp_bus_q.pop_front();
        n_tests++; if (snap !== eb) begin n_fail++; $display("FAIL store_bus: got %h want %h", snap, eb); end
        n_tests++; if (rdata !== last_rd) begin n_fail++; $display("FAIL store_rdata_kept: got %h want %h", rdata, last_rd); end
    endtask

    task automatic test_noop_store;
        int sc, rc, un, rv, ec;
        bus_t snap;
        logic [31:0] rd;
        do_access(1'b1, 32'h0000_4000, 32'h1111_2222, 4'b0000, 2, 32'h0,
                  sc, rc, un, rv, ec, snap, rd);
        n_tests++; if (sc !== 0) begin n_fail++; $display("FAIL noop_stall: got %0d cycles want 0", sc); end
        n_tests++; if (rc !== 0) begin n_fail++; $display("FAIL noop_bus_req: got %0d cycles want 0", rc); end
        n_tests++; if (rv !== 0) begin n_fail++; $display("FAIL noop_rdata_valid: got %0d want 0", rv); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        int sc, rc, un, rv, ec;
        bus_t snap;
        logic [31:0] rd, er;
        exp_rd_q.push_back(32'h0);
        do_access(1'b0, 32'h0000_5000, 32'h0, 4'b0000, -1, 32'hFFFF_FFFF,
                  sc, rc, un, rv, ec, snap, rd);
        n_tests++; if (rc !== 4) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 4", rc); end
        n_tests++; if (ec !== 1) begin n_fail++; $display("FAIL timeout_bus_err: got %0d pulses want 1", ec); end
        n_tests++; if (sc !== 5) begin n_fail++; $display("FAIL timeout_stall: got %0d want 5", sc); end
        n_tests++; if (rv !== 1) begin n_fail++; $display("FAIL timeout_rdata_valid: got %0d want 1", rv); end
        er = exp_rd_q.pop_front();
        n_tests++; if (rd !== er) begin n_fail++; $display("FAIL timeout_rdata: got %h want %h", rd, er); end
        last_rd = er;
    endtask
`else
    task automatic test_long_wait;
        int sc, rc, un, rv, ec;
        bus_t snap;
        logic [31:0] rd, er;
        exp_rd_q.push_back(32'hCAFE_F00D);
        do_access(1'b0, 32'h0000_5004, 32'h0, 4'b0000, 20, 32'hCAFE_F00D,
                  sc, rc, un, rv, ec, snap, rd);
        n_tests++; if (rc !== 21) begin n_fail++; $display("FAIL longwait_req_cycles: got %0d want 21", rc); end
        n_tests++; if (ec !== 0) begin n_fail++; $display("FAIL longwait_bus_err: got %0d want 0", ec); end
        er = exp_rd_q.pop_front();
        n_tests++; if (rd !== er) begin n_fail++; $display("FAIL longwait_rdata: got %h want %h", rd, er); end
        last_rd = er;
    endtask
`endif

    task automatic test_back_to_back;
        int txn = 0, rv = 0, done1 = -1, start2 = -1;
        logic prev_req = 1'b0;
        logic [31:0] er;
        exp_rd_q.push_back(32'h1111_0001);
        exp_rd_q.push_back(32'h2222_0002);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_6000;
        req_wdata = '0; req_byte_en = '0; bus_rdata = 32'h1111_0001;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (bus_req && !prev_req) begin
                txn++;
                if (txn == 2) start2 = c;
            end
            prev_req = bus_req;
            bus_ack = bus_req;
            if (rdata_valid) begin
                rv++;
                er = exp_rd_q.pop_front();
                n_tests++; if (rdata !== er) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h want %h", rv, rdata, er); end
                if (rv == 1) begin
                    done1 = c;
                    req_addr = 32'h0000_6004;
                    bus_rdata = 32'h2222_0002;
                end else begin
                    req_valid = 1'b0;
                end
            end
            tick();
        end
        bus_ack = 1'b0;
        req_valid = 1'b0;
        n_tests++; if (txn !== 2) begin n_fail++; $display("FAIL b2b_transactions: got %0d want 2", txn); end
        n_tests++; if (start2 !== done1 + 2) begin n_fail++; $display("FAIL b2b_second_start: got cycle %0d want %0d", start2, done1 + 2); end
        last_rd = 32'h2222_0002;
    endtask

    task automatic test_reset_mid_req;
        int bad_rv = 0, bad_req = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_7000;
        bus_rdata = 32'h7777_7777; bus_ack = 1'b0;
        #1;
        tick();
        tick();
        n_tests++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL midreq_in_req: got bus_req %b want 1", bus_req); end
        reset = 1'b1;
        #1;
        n_tests++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL midreq_async_drop: got bus_req %b want 0", bus_req); end
        req_valid = 1'b0;
        bus_ack = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (rdata_valid) bad_rv++;
            if (bus_req) bad_req++;
        end
        bus_ack = 1'b0;
        n_tests++; if (bad_rv !== 0) begin n_fail++; $display("FAIL midreq_rdata_valid: got %0d pulses want 0", bad_rv); end
        n_tests++; if (bad_req !== 0) begin n_fail++; $display("FAIL midreq_bus_req: got %0d cycles want 0", bad_req); end
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midreq_rdata: got %h want 0", rdata); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midreq_stall: got %b want 0", stall); end
        last_rd = 32'h0;
    endtask

    initial begin
        test_reset();
        test_load(32'h0000_1006, 32'hDEAD_BEEF, 0);
        test_load(32'h0000_2003, 32'h1234_5678, 1);
        test_store();
        test_noop_store();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_back_to_back();
        test_reset_mid_req();
        // A fresh access after the abandoned one shows the FSM restarted in IDLE.
        test_load(32'h0000_8000, 32'h0BAD_F00D, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of REQ-state cycles before a timeout; it is used only when MEM_TIMEOUT_EN is defined.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-004 Port req_valid, input, 1 bit, SHALL indicate that the MEM stage holds a memory access.
REQ-005 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 Port req_addr, input, 32 bits: byte address.
REQ-007 Port req_wdata, input, 32 bits: store data, already lane-aligned.
REQ-008 Port req_byte_en, input, 4 bits: store byte lanes, from the byte selector.
REQ-009 Port stall, output, 1 bit: freezes the pipeline.
REQ-010 Port rdata, output, 32 bits: raw load word to the byte extender.
REQ-011 Port rdata_valid, output, 1 bit: load-completion pulse.
REQ-012 Port bus_req, output, 1 bit, and port bus_we, output, 1 bit, SHALL form the memory bus request.
REQ-013 Port bus_addr, output, 32 bits; port bus_wdata, output, 32 bits; port bus_be, output, 4 bits.
REQ-014 Port bus_ack, input, 1 bit, and port bus_rdata, input, 32 bits, SHALL form the memory bus response.
REQ-015 Port bus_err, output, 1 bit, SHALL be the timeout pulse.

Function
REQ-016 FSM states SHALL be IDLE, REQ and DONE, and every FSM output SHALL be registered except stall.
REQ-017 IDLE: when req_valid=1 and not (req_we=1 and req_byte_en=4'b0000), the block SHALL latch the request and move to REQ next cycle; otherwise it SHALL remain in IDLE.
REQ-018 A store with req_byte_en=4'b0000 SHALL be a no-op: no bus activity, no stall.
REQ-019 stall SHALL equal (IDLE and an accepted request is present) OR (state==REQ); stall SHALL be 0 in DONE.
REQ-020 In REQ, bus_req SHALL be 1.
REQ-021 In REQ, bus_addr SHALL be {latched addr[31:2],2'b00}, and bus_we and bus_wdata SHALL be the latched values.
REQ-022 In REQ, bus_be SHALL be the latched byte enable for stores and 4'b1111 for loads.
REQ-023 All bus outputs SHALL remain stable until bus_ack is sampled high.
REQ-024 Outside REQ, bus_req SHALL be 0 and bus_be SHALL be 4'b0000.
REQ-025 bus_ack SHALL be sampled only in REQ; in IDLE and DONE it SHALL be ignored.
REQ-026 On bus_ack=1 in REQ, a load SHALL register bus_rdata into rdata, and the FSM SHALL move to DONE.
REQ-027 DONE SHALL last exactly 1 cycle, then the FSM SHALL return to IDLE.
REQ-028 rdata_valid SHALL be 1 in DONE for loads only.
REQ-029 req_valid present during DONE SHALL be treated as the completed instruction and SHALL NOT be re-issued.
REQ-030 rdata SHALL hold its value until the next load completes; stores SHALL leave rdata unchanged.
REQ-031 Minimum access SHALL be 3 cycles (accept, REQ with ack, DONE), giving 2 stall cycles; each extra REQ cycle SHALL add 1 stall cycle.

Reset
REQ-032 On reset, the FSM SHALL be IDLE, and rdata SHALL be 32'h0.
REQ-033 On reset, rdata_valid, bus_req, bus_we, bus_err, bus_be and bus_addr SHALL be 0, and the timeout counter SHALL be 0.
REQ-034 Reset asserted mid-REQ SHALL drop bus_req asynchronously and abandon the access; a later bus_ack SHALL be ignored.

Configuration
REQ-035 The macro MEM_TIMEOUT_EN SHALL control the REQ-state timeout.
REQ-036 With MEM_TIMEOUT_EN defined, a counter SHALL count REQ cycles (cleared on REQ entry) up to TIMEOUT_CYCLES.
REQ-037 With MEM_TIMEOUT_EN defined and the count reached without ack, the FSM SHALL enter DONE with bus_err=1 for that cycle.
REQ-038 On such a timeout, a load SHALL set rdata to 32'h0 and assert rdata_valid.
REQ-039 With MEM_TIMEOUT_EN defined, bus_ack in the same cycle as the timeout SHALL win, with no error.
REQ-040 Without MEM_TIMEOUT_EN, REQ SHALL wait indefinitely, bus_err SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-041 Load addr=0x0000_1006, ack on 1st REQ cycle with bus_rdata=0xDEADBEEF -> bus_addr=0x0000_1004, bus_be=1111, stall high 2 cycles, rdata=0xDEADBEEF, rdata_valid 1 cycle.
REQ-042 Store be=4'b1100, wdata=0xABCD0000, ack delayed 3 cycles -> bus signals stable 4 REQ cycles, stall high 5 cycles, rdata unchanged, rdata_valid stays 0.
REQ-043 Store with be=4'b0000 -> bus_req never asserted, stall stays 0.
REQ-044 Reset asserted in the 2nd REQ cycle, then ack -> bus_req 0 immediately, FSM IDLE, rdata=0, no rdata_valid.
REQ-045 MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack on a load -> bus_err pulse after 4 REQ cycles, rdata=0, stall released.
REQ-046 Back-to-back loads with req_valid held through DONE -> exactly two bus transactions, second accepted the cycle after DONE.
